td4_core_param: RTL

- Parametrised successor of the TD4 4-bit CPU core.
- Generalises the data/immediate width (DW) and the program-counter width (AW).
- Replaces the combinational switch-ROM instruction input with a request/valid fetch handshake, so slow or external instruction memory can stall the core.
- Sits between the instruction-memory adapter and the I/O pins of the top-level wrapper.

---
 rtl/td4_pkg.sv | 38 +++
 rtl/td4_alu_param.sv | 13 +
 rtl/td4_core_param.sv | 135 +++++++++++++
 3 files changed

// File: rtl/td4_pkg.sv
// Shared encodings for the parametrised TD4 core: opcodes, FSM states,
// ALU source selects and the decoded control bundle.
package td4_pkg;

   localparam logic [3:0] OP_ADD_A  = 4'b0000;
   localparam logic [3:0] OP_MOV_AB = 4'b0001;
   localparam logic [3:0] OP_IN_A   = 4'b0010;
   localparam logic [3:0] OP_MOV_A  = 4'b0011;
   localparam logic [3:0] OP_MOV_BA = 4'b0100;
   localparam logic [3:0] OP_ADD_B  = 4'b0101;
   localparam logic [3:0] OP_IN_B   = 4'b0110;
   localparam logic [3:0] OP_MOV_B  = 4'b0111;
   localparam logic [3:0] OP_OUT_B  = 4'b1001;
   localparam logic [3:0] OP_OUT_IM = 4'b1011;
   localparam logic [3:0] OP_HALT   = 4'b1100;
   localparam logic [3:0] OP_JNC    = 4'b1110;
   localparam logic [3:0] OP_JMP    = 4'b1111;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [1:0] SEL_A    = 2'd0;
   localparam logic [1:0] SEL_B    = 2'd1;
   localparam logic [1:0] SEL_IN   = 2'd2;
   localparam logic [1:0] SEL_ZERO = 2'd3;

   typedef struct packed {
      logic [1:0] sel;
      logic       wr_a;
      logic       wr_b;
      logic       wr_out;
      logic       cf_we;
      logic       jump;
      logic       halt;
   } ctrl_t;

endpackage

// File: rtl/td4_alu_param.sv
// DW-bit adder with carry-out; carry-in is always zero.
module td4_alu_param #(
   parameter int DW = 4
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] sum,
   output logic          carry
);

   assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/td4_core_param.sv
// Parametrised TD4 core with a req/valid instruction fetch handshake.
// Define TD4_HALT_EN to make opcode 1100 enter an absorbing HALT state.
module td4_core_param
   import td4_pkg::*;
#(
   parameter int            DW     = 4,
   parameter int            AW     = 4,
   parameter logic [AW-1:0] RST_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_valid,
   input  logic [DW+3:0] imem_data,
   input  logic [DW-1:0] in_port,
   output logic [DW-1:0] out_port,
   output logic          cf,
   output logic          halted
);

   logic [1:0]    state;
   logic [AW-1:0] pc;
   logic [DW+3:0] ir;
   logic [DW-1:0] reg_a, reg_b;

   logic [3:0]    opcode;
   logic [DW-1:0] imm;
   ctrl_t         ctrl;
   logic [DW-1:0] src, sum;
   logic          carry;
   logic [AW-1:0] target;

   assign opcode = ir[DW+3:DW];
   assign imm    = ir[DW-1:0];

   // Cases whose cf result must be 0 all add Im to zero, so the carry is 0 there.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      ctrl = '{sel: SEL_ZERO, wr_a: 1'b0, wr_b: 1'b0, wr_out: 1'b0,
               cf_we: 1'b1, jump: 1'b0, halt: 1'b0};
      case (opcode)
         OP_ADD_A:  begin ctrl.sel = SEL_A;  ctrl.wr_a = 1'b1; end
         OP_MOV_AB: begin ctrl.sel = SEL_B;  ctrl.wr_a = 1'b1; end
         OP_IN_A:   begin ctrl.sel = SEL_IN; ctrl.wr_a = 1'b1; end
         OP_MOV_A:  ctrl.wr_a = 1'b1;
         OP_MOV_BA: begin ctrl.sel = SEL_A;  ctrl.wr_b = 1'b1; end
         OP_ADD_B:  begin ctrl.sel = SEL_B;  ctrl.wr_b = 1'b1; end
         OP_IN_B:   begin ctrl.sel = SEL_IN; ctrl.wr_b = 1'b1; end
         OP_MOV_B:  ctrl.wr_b = 1'b1;
         OP_OUT_B:  begin ctrl.sel = SEL_B;  ctrl.wr_out = 1'b1; end
         OP_OUT_IM: ctrl.wr_out = 1'b1;
         OP_JMP:    ctrl.jump = 1'b1;
         OP_JNC:    ctrl.jump = ~cf;
`ifdef TD4_HALT_EN
         OP_HALT:   begin ctrl.halt = 1'b1; ctrl.cf_we = 1'b0; end
`else
         OP_HALT:   ctrl.cf_we = 1'b0;
`endif
         default:   ctrl.cf_we = 1'b0;
      endcase
   end

   always_comb begin
      case (ctrl.sel)
         SEL_A:   src = reg_a;
         SEL_B:   src = reg_b;
         SEL_IN:  src = in_port;
         default: src = '0;
      endcase
   end

   td4_alu_param #(.DW(DW)) u_alu (
      .a     (src),
      .b     (imm),
      .sum   (sum),
      .carry (carry)
   );

   generate
      if (AW > DW) begin : g_tgt_ext
         assign target = {{(AW-DW){1'b0}}, imm};
      end else begin : g_tgt_trunc
         assign target = imm[AW-1:0];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_FETCH;
         pc       <= RST_PC;
         ir       <= '0;
         reg_a    <= '0;
         reg_b    <= '0;
         out_port <= '0;
         cf       <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
         case (state)
            ST_FETCH: begin
               if (imem_valid) begin
                  ir    <= imem_data;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (ctrl.wr_a)   reg_a    <= sum;
               if (ctrl.wr_b)   reg_b    <= sum;
               if (ctrl.wr_out) out_port <= sum;
               if (ctrl.cf_we)  cf       <= carry;
               if (ctrl.halt) begin
                  state <= ST_HALT;
               end else begin
                  pc    <= ctrl.jump ? target : pc + 1'b1;
                  state <= ST_FETCH;
               end
            end
`ifdef TD4_HALT_EN
            ST_HALT: state <= ST_HALT;
`endif
            default: state <= ST_FETCH;
         endcase
      end
   end

   assign imem_req  = (state == ST_FETCH);
   assign imem_addr = pc;

`ifdef TD4_HALT_EN
   assign halted = (state == ST_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule
